// File: rtl/pb_port_hold_decoder.sv
// rtl/pb_port_hold_decoder.sv - registered port_id hold decoder with stretched active-low strobes
module pb_port_hold_decoder #(
  parameter int                N_CH        = 9,
  parameter logic [N_CH*8-1:0] ADDR_MAP    = {8'h0C, 8'h0B, 8'h0A, 8'h08, 8'h07,
                                              8'h06, 8'h05, 8'h04, 8'h03},
  parameter int                DATA_W      = 8,
  parameter int                HOLD_CYCLES = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              write_strobe,
  input  logic [7:0]        port_id,
  input  logic [DATA_W-1:0] out_port,
  input  logic [N_CH-1:0]   ch_enable,
  input  logic              err_clr,
  output logic [N_CH-1:0]   hold_n,
  output logic [DATA_W-1:0] data_q,
  output logic [3:0]        active_ch,
  output logic              busy,
  output logic              err_unmapped
);

  localparam int         CH_W   = (N_CH > 1) ? $clog2(N_CH) : 1;
  localparam logic [7:0] RELOAD = 8'(HOLD_CYCLES - 1);

  typedef enum logic {IDLE, HOLD} state_t;

  state_t            state;
  logic [7:0]        cnt;
  logic              hit;
  logic [CH_W-1:0]   hit_idx;
  logic [N_CH-1:0]   hit_onehot;

  // Scan from the top down so the lowest matching index is the one left standing.
  always_comb begin
    hit     = 1'b0;
    hit_idx = '0;
    for (int i = N_CH - 1; i >= 0; i--) begin
      if (write_strobe && ch_enable[i] && (port_id == ADDR_MAP[i*8 +: 8])) begin
        hit     = 1'b1;
        hit_idx = CH_W'(i);
      end
    end
    hit_onehot = '0;
    for (int i = 0; i < N_CH; i++) begin
      hit_onehot[i] = hit && (i == int'(hit_idx));
    end
  end

  // A new match always wins over the running stretch, so only one strobe is ever low.
  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= IDLE;
      cnt          <= '0;
      hold_n       <= '1;
      data_q       <= '0;
      active_ch    <= '0;
      busy         <= 1'b0;
      err_unmapped <= 1'b0;
    end else begin
      if (hit) begin
        state     <= HOLD;
        cnt       <= RELOAD;
        hold_n    <= ~hit_onehot;
        data_q    <= out_port;
        active_ch <= 4'(hit_idx);
        busy      <= 1'b1;
      end else if (state == HOLD) begin
        if (cnt != 8'd0) begin
          cnt <= cnt - 8'd1;
        end else begin
          state     <= IDLE;
          hold_n    <= '1;
          active_ch <= '0;
          busy      <= 1'b0;
        end
      end

      if (write_strobe && !hit) begin
        err_unmapped <= 1'b1;
      end else if (err_clr) begin
        err_unmapped <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_pb_port_hold_decoder.sv
// tb/tb_pb_port_hold_decoder.sv - self-checking bench for pb_port_hold_decoder
module tb_pb_port_hold_decoder;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       write_strobe = 1'b0;
  logic [7:0] port_id = 8'h00;
  logic [7:0] out_port = 8'h00;
  logic [8:0] ch_enable = 9'h1FF;
  logic       err_clr = 1'b0;

  logic [8:0] hn0, hn1, hn2;
  logic [1:0] hn3;
  logic [7:0] dq0, dq1, dq2, dq3;
  logic [3:0] ac0, ac1, ac2, ac3;
  logic       bz0, bz1, bz2, bz3;
  logic       er0, er1, er2, er3;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  pb_port_hold_decoder #(.HOLD_CYCLES(1)) d0 (
    .clk(clk), .reset(reset), .write_strobe(write_strobe), .port_id(port_id),
    .out_port(out_port), .ch_enable(ch_enable), .err_clr(err_clr),
    .hold_n(hn0), .data_q(dq0), .active_ch(ac0), .busy(bz0), .err_unmapped(er0));

  pb_port_hold_decoder #(.HOLD_CYCLES(4)) d1 (
    .clk(clk), .reset(reset), .write_strobe(write_strobe), .port_id(port_id),
    .out_port(out_port), .ch_enable(ch_enable), .err_clr(err_clr),
    .hold_n(hn1), .data_q(dq1), .active_ch(ac1), .busy(bz1), .err_unmapped(er1));

  pb_port_hold_decoder #(.HOLD_CYCLES(8)) d2 (
    .clk(clk), .reset(reset), .write_strobe(write_strobe), .port_id(port_id),
    .out_port(out_port), .ch_enable(ch_enable), .err_clr(err_clr),
    .hold_n(hn2), .data_q(dq2), .active_ch(ac2), .busy(bz2), .err_unmapped(er2));

  pb_port_hold_decoder #(.N_CH(2), .ADDR_MAP({8'h20, 8'h20}), .HOLD_CYCLES(4)) d3 (
    .clk(clk), .reset(reset), .write_strobe(write_strobe), .port_id(port_id),
    .out_port(out_port), .ch_enable(ch_enable[1:0]), .err_clr(err_clr),
    .hold_n(hn3), .data_q(dq3), .active_ch(ac3), .busy(bz3), .err_unmapped(er3));

  // Reference model: each instance remembers how many low cycles remain,
  // which channel owns the strobe, the captured byte and the sticky error.
  int        m_hold[4] = '{1, 4, 8, 4};
  int        m_nch[4]  = '{9, 9, 9, 2};
  int        m_rem[4];
  int        m_chan[4];
  logic [7:0] m_data[4];
  bit        m_err[4];
  logic [7:0] dflt_map[9] = '{8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08, 8'h0A, 8'h0B, 8'h0C};

  function automatic logic [7:0] map_of(int k, int i);
    if (k == 3) return 8'h20;
    return dflt_map[i];
  endfunction

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_edge(bit rs, bit ws, logic [7:0] pid, logic [7:0] d, logic [8:0] en, bit clr);
    for (int k = 0; k < 4; k++) begin
      if (rs) begin
        m_rem[k] = 0; m_chan[k] = 0; m_data[k] = 8'h00; m_err[k] = 1'b0;
      end else begin
        int found;
        found = -1;
        if (ws)
          for (int i = 0; i < m_nch[k]; i++)
            if (found < 0 && en[i] && map_of(k, i) == pid) found = i;
        if (found >= 0) begin
          m_chan[k] = found; m_data[k] = d; m_rem[k] = m_hold[k];
        end else if (m_rem[k] > 0) begin
          m_rem[k]--;
        end
        if (ws && found < 0) m_err[k] = 1'b1;
        else if (clr) m_err[k] = 1'b0;
      end
    end
  endtask

  task automatic check_all();
    for (int k = 0; k < 4; k++) begin
      logic [31:0] ohn, odq, oac, obz, oer, ehn, mask;
      case (k)
        0: begin ohn = 32'(hn0); odq = 32'(dq0); oac = 32'(ac0); obz = 32'(bz0); oer = 32'(er0); end
        1: begin ohn = 32'(hn1); odq = 32'(dq1); oac = 32'(ac1); obz = 32'(bz1); oer = 32'(er1); end
        2: begin ohn = 32'(hn2); odq = 32'(dq2); oac = 32'(ac2); obz = 32'(bz2); oer = 32'(er2); end
        default: begin ohn = 32'(hn3); odq = 32'(dq3); oac = 32'(ac3); obz = 32'(bz3); oer = 32'(er3); end
      endcase
      mask = (32'd1 << m_nch[k]) - 32'd1;
      ehn  = (m_rem[k] > 0) ? (mask & ~(32'd1 << m_chan[k])) : mask;
      chk($sformatf("inst%0d hold_n", k), ohn, ehn);
      chk($sformatf("inst%0d data_q", k), odq, 32'(m_data[k]));
      chk($sformatf("inst%0d active_ch", k), oac, (m_rem[k] > 0) ? 32'(m_chan[k]) : 32'd0);
      chk($sformatf("inst%0d busy", k), obz, (m_rem[k] > 0) ? 32'd1 : 32'd0);
      chk($sformatf("inst%0d err_unmapped", k), oer, 32'(m_err[k]));
    end
  endtask

  task automatic step(bit rs, bit ws, logic [7:0] pid, logic [7:0] d, logic [8:0] en, bit clr);
    reset = rs; write_strobe = ws; port_id = pid; out_port = d; ch_enable = en; err_clr = clr;
    @(posedge clk);
    model_edge(rs, ws, pid, d, en, clr);
    #1;
    check_all();
  endtask

  task automatic idle(int n);
    for (int j = 0; j < n; j++) step(1'b0, 1'b0, 8'h00, 8'h00, 9'h1FF, 1'b0);
  endtask

  logic [7:0] pool[12] = '{8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08,
                           8'h0A, 8'h0B, 8'h0C, 8'h20, 8'h09, 8'h00};

  initial begin
    for (int k = 0; k < 4; k++) begin
      m_rem[k] = 0; m_chan[k] = 0; m_data[k] = 8'h00; m_err[k] = 1'b0;
    end
    // reset state
    step(1'b1, 1'b0, 8'h00, 8'h00, 9'h1FF, 1'b0);
    step(1'b1, 1'b0, 8'h00, 8'h00, 9'h1FF, 1'b0);
    chk("reset hold_n", 32'(hn0), 32'h1FF);

    // single-cycle pulse on channel 2
    step(1'b0, 1'b1, 8'h05, 8'h37, 9'h1FF, 1'b0);
    chk("t1 hold_n low", 32'(hn0), 32'h1FB);
    chk("t1 data_q", 32'(dq0), 32'h37);
    chk("t1 active_ch", 32'(ac0), 32'd2);
    idle(1);
    chk("t1 hold_n released", 32'(hn0), 32'h1FF);
    idle(8);

    // four-cycle stretch on channel 6
    step(1'b0, 1'b1, 8'h0A, 8'h5A, 9'h1FF, 1'b0);
    idle(3);
    chk("t2 hold_n[6] still low", 32'(hn1[6]), 32'd0);
    idle(1);
    chk("t2 hold_n released", 32'(hn1), 32'h1FF);
    idle(8);

    // preemption: channel 0 then channel 8
    step(1'b0, 1'b1, 8'h03, 8'h11, 9'h1FF, 1'b0);
    idle(1);
    step(1'b0, 1'b1, 8'h0C, 8'h22, 9'h1FF, 1'b0);
    chk("t3 preempt hold_n", 32'(hn1), 32'h0FF);
    chk("t3 data_q", 32'(dq1), 32'h22);
    idle(10);

    // unmapped / disabled writes and err_clr priority
    step(1'b0, 1'b1, 8'h09, 8'hAA, 9'h1FF, 1'b0);
    chk("t4 err set", 32'(er0), 32'd1);
    step(1'b0, 1'b1, 8'h06, 8'hBB, 9'h1F7, 1'b0);
    chk("t4 disabled hold_n", 32'(hn1), 32'h1FF);
    step(1'b0, 1'b0, 8'h00, 8'h00, 9'h1FF, 1'b1);
    chk("t4 err cleared", 32'(er0), 32'd0);
    step(1'b0, 1'b1, 8'h09, 8'hCC, 9'h1FF, 1'b1);
    chk("t4 set wins", 32'(er0), 32'd1);

    // reset mid-stretch, then an immediate write
    step(1'b0, 1'b1, 8'h07, 8'h44, 9'h1FF, 1'b0);
    idle(2);
    chk("t5 hold_n[4] low", 32'(hn2), 32'h1EF);
    step(1'b1, 1'b0, 8'h00, 8'h00, 9'h1FF, 1'b0);
    chk("t5 reset hold_n", 32'(hn2), 32'h1FF);
    step(1'b0, 1'b1, 8'h08, 8'h55, 9'h1FF, 1'b0);
    chk("t5 accept after reset", 32'(hn2), 32'h1DF);
    idle(10);

    // duplicate map entries
    step(1'b0, 1'b1, 8'h20, 8'h66, 9'h1FF, 1'b0);
    chk("t6 lowest index", 32'(hn3), 32'h2);
    idle(5);

    // randomized traffic
    for (int n = 0; n < 600; n++) begin
      bit         rs, ws, clr;
      logic [7:0] pid;
      logic [8:0] en;
      rs  = ($urandom_range(0, 59) == 0);
      ws  = ($urandom_range(0, 2) != 0);
      pid = ($urandom_range(0, 7) == 0) ? 8'($urandom) : pool[$urandom_range(0, 11)];
      en  = ($urandom_range(0, 3) == 0) ? 9'($urandom) : 9'h1FF;
      clr = ($urandom_range(0, 5) == 0);
      step(rs, ws, pid, 8'($urandom), en, clr);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/pb_port_hold_decoder.md
Name: pb_port_hold_decoder

Overview:
- Parametrised, registered successor to the combinational port_id hold decoder.
- Maps processor write cycles (write_strobe, port_id, out_port) onto N_CH active-low per-register hold strobes through a configurable address map.
- Captures the written byte and stretches each strobe for HOLD_CYCLES clocks, so slow-domain time/date/timer registers see a clean, glitch-free load window.
- Flags writes to unmapped ports in a sticky error bit; sits between the soft processor and the clock/date/timer register bank.

Parameters:
- N_CH, 9, number of hold channels (1..16).
- ADDR_MAP, {8'h0C,8'h0B,8'h0A,8'h08,8'h07,8'h06,8'h05,8'h04,8'h03}, N_CH*8-bit packed vector; byte i is the port_id of channel i.
- DATA_W, 8, width of out_port and data_q.
- HOLD_CYCLES, 1, number of clocks each hold strobe stays low (1..255).

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- write_strobe  in  1  processor write qualifier, one clock wide.
- port_id  in  8  processor port address.
- out_port  in  DATA_W  processor write data.
- ch_enable  in  N_CH  per-channel enable; a disabled channel is treated as unmapped.
- err_clr  in  1  clears err_unmapped.
- hold_n  out  N_CH  active-low hold/load strobes; at most one bit is low at a time.
- data_q  out  DATA_W  last accepted write data.
- active_ch  out  4  index of the channel currently held low (0 when idle).
- busy  out  1  high while any hold_n bit is low.
- err_unmapped  out  1  sticky flag: a write hit an unmapped or disabled port.

Behaviour:
- Reset, applied on the rising clk edge while reset=1:
  - hold_n = all 1s; data_q = 0; active_ch = 0; busy = 0; err_unmapped = 0.
  - Stretch counter = 0; FSM enters IDLE.
  - Reset asserted mid-HOLD releases the strobe on the next edge.
- Match rule: write_strobe=1 and port_id == ADDR_MAP[i] with ch_enable[i]=1. If duplicate entries exist, the lowest index wins.
- FSM states: IDLE, HOLD.
- IDLE:
  - On a matching write: next cycle hold_n[i]=0, data_q=out_port, active_ch=i, busy=1, counter=HOLD_CYCLES-1; go to HOLD.
  - Latency from the strobe edge to hold_n low is exactly 1 clock.
- HOLD:
  - counter>0: decrement, strobe stays low.
  - counter==0 with no new match: hold_n = all 1s, busy=0, active_ch=0; go to IDLE.
  - HOLD_CYCLES=1 therefore gives a single-cycle low pulse.
- New matching write while in HOLD (any counter value):
  - Preempts: the previous channel is released and the new channel is low on the same next edge. Never two bits low at once.
  - data_q is updated and the counter reloads to HOLD_CYCLES-1.
  - Back-to-back writes each produce a low strobe with no idle gap.
- Unmapped or disabled write:
  - err_unmapped=1 on the next edge.
  - hold_n, data_q and the FSM are unaffected; an ongoing HOLD continues.
- err_clr: clears err_unmapped on the next edge. If a new unmapped write arrives in the same cycle as err_clr, set wins.
- write_strobe=0: port_id and out_port are ignored entirely.
- Widths: the counter is 8 bits. active_ch is zero-extended from clog2(N_CH).

Test Plan:
1. Default params; reset, then write_strobe with port_id=8'h05, out_port=8'h37 -> 1 clk later hold_n=9'h1FB, data_q=8'h37, active_ch=2, busy=1; next clk hold_n=9'h1FF, busy=0.
2. HOLD_CYCLES=4; write 8'h0A -> hold_n[6]=0 for exactly 4 clks, then all 1s; busy mirrors the low window.
3. HOLD_CYCLES=4; write 8'h03, then 2 clks later write 8'h0C -> hold_n[0] rises on the same edge hold_n[8] falls; hold_n[8] stays low 4 clks; data_q holds the second byte.
4. Write 8'h09 (unmapped), then ch_enable[3]=0 and write 8'h06 -> err_unmapped=1 after the first write; hold_n stays all 1s for both; err_clr alone clears the flag; err_clr coincident with an 8'h09 write leaves it 1.
5. Assert reset while hold_n[4]=0 during a HOLD_CYCLES=8 stretch -> next edge all outputs at reset values; a write in the cycle after reset deasserts is accepted normally.
6. N_CH=2, ADDR_MAP={8'h20,8'h20}; write 8'h20 -> only hold_n[0] goes low (lowest index wins).
